ring_decoder: RTL and testbench

Receive-side monitor for the 4-bit one-hot ring sequence (1000→0100→0010→0001→1000) produced by our ring-counter FSM. It samples the ring word every enabled cycle and decodes it to a 2-bit index. It checks each sample against the expected successor, acquires and holds lock, and reports sequence errors and full-rotation counts. It sits at the consuming end of the ring bus, in the same clock domain as the generator.

---
 rtl/ring_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_ring_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
// ring_decoder
//   Receive-side monitor for the 4-bit one-hot ring sequence
//   1000 -> 0100 -> 0010 -> 0001 -> 1000. The ring word is registered,
//   decoded to a 2-bit index, and checked against the expected successor.
//   A three-state tracker (SEARCH / ACQ / LOCK) acquires and holds lock,
//   pulses ERR on sequence errors while locked and WRAP on each full
//   rotation, and keeps a saturating error count and a wrapping rotation count.
//
// Ports
//   CLK        in   clock, rising edge
//   RESET      in   synchronous active-high reset, overrides all other inputs
//   EN         in   evaluation enable for the tracker and counters
//   CLR_CNT    in   synchronous clear of ERR_CNT and WRAP_CNT
//   Y_IN       in   [3:0] ring word from the generator
//   IDX        out  [1:0] decoded index (1000->0 ... 0001->3), held on bad words
//   IDX_VALID  out  registered word was exactly one-hot
//   LOCKED     out  tracker is in LOCK
//   ERR        out  one-cycle pulse per sequence error while locked
//   ERR_CNT    out  [CNT_W-1:0] error count, saturating
//   WRAP       out  one-cycle pulse on a 3->0 step taken while locked
//   WRAP_CNT   out  [CNT_W-1:0] rotation count, modulo 2^CNT_W

module ring_decoder #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 2,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             CLR_CNT,
    input  logic [3:0]       Y_IN,
    output logic [1:0]       IDX,
    output logic             IDX_VALID,
    output logic             LOCKED,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             WRAP,
    output logic [CNT_W-1:0] WRAP_CNT
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCK   = 2'd2
    } state_t;

    // Stage 1: input register
    logic [3:0] y_d, y_q;

    // Stage 2: decode of y_q
    logic [3:0] hot_vec;
    logic       onehot;
    logic [1:0] cur_idx;
    logic       is_step;
    logic       is_hold;

    // Tracker and output state
    state_t           state_d, state_q;
    logic [1:0]       prev_idx_d, prev_idx_q;
    logic [GW-1:0]    good_cnt_d, good_cnt_q;
    logic [BW-1:0]    bad_cnt_d, bad_cnt_q;
    logic [1:0]       idx_d, idx_q;
    logic             idx_valid_d, idx_valid_q;
    logic             err_d, err_q;
    logic             wrap_d, wrap_q;
    logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
    logic [CNT_W-1:0] wrap_cnt_d, wrap_cnt_q;

    always_comb begin
        y_d = Y_IN;
    end

    // hot_vec[gi] is set when y_q is exactly the one-hot word for index gi.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dec
            localparam logic [3:0] PAT = 4'b1000 >> gi;
            assign hot_vec[gi] = (y_q == PAT);
        end
    endgenerate

    // At most one hot_vec bit can be set, so a plain OR-encoder suffices.
    assign onehot  = |hot_vec;
    assign cur_idx = {hot_vec[2] | hot_vec[3], hot_vec[1] | hot_vec[3]};
    // Index arithmetic is 2 bits wide, so prev_idx_q + 1 wraps 3 -> 0.
    assign is_step = onehot && (cur_idx == prev_idx_q + 2'd1);
    assign is_hold = onehot && (cur_idx == prev_idx_q);

    always_comb begin
        state_d    = state_q;
        prev_idx_d = prev_idx_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        err_d      = 1'b0;
        wrap_d     = 1'b0;

        if (EN) begin
            unique case (state_q)
                ST_SEARCH: begin
                    if (onehot) begin
                        prev_idx_d = cur_idx;
                        good_cnt_d = '0;
                        state_d    = ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (is_step) begin
                        prev_idx_d = cur_idx;
                        good_cnt_d = good_cnt_q + GW'(1);
                        if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
                            state_d   = ST_LOCK;
                            bad_cnt_d = '0;
                        end
                    end else if (is_hold) begin
                        // generator may legally sit on one word
                    end else if (onehot) begin
                        // valid word out of order: restart acquisition from it
                        prev_idx_d = cur_idx;
                        good_cnt_d = '0;
                    end else begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_LOCK: begin
                    if (is_step) begin
                        bad_cnt_d  = '0;
                        prev_idx_d = cur_idx;
                        wrap_d     = (cur_idx == 2'd0);
                    end else if (is_hold) begin
                        // legal hold, nothing changes
                    end else begin
                        err_d     = 1'b1;
                        bad_cnt_d = bad_cnt_q + BW'(1);
                        if (onehot) begin
                            prev_idx_d = cur_idx;
                        end
                        if (bad_cnt_q == BW'(ERR_LIMIT - 1)) begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    // Counters: clear wins over a same-cycle increment; the pulse itself
    // is unaffected by the clear.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        if (CLR_CNT) begin
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end else begin
            if (err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (wrap_d) begin
                wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
            end
        end
    end

    // Decoded index keeps its last good value across non-one-hot words.
    always_comb begin
        idx_d       = onehot ? cur_idx : idx_q;
        idx_valid_d = onehot;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            y_q         <= '0;
            state_q     <= ST_SEARCH;
            prev_idx_q  <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
        end else begin
            y_q         <= y_d;
            state_q     <= state_d;
            prev_idx_q  <= prev_idx_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            err_q       <= err_d;
            wrap_q      <= wrap_d;
            err_cnt_q   <= err_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
        end
    end

    assign IDX       = idx_q;
    assign IDX_VALID = idx_valid_q;
    assign LOCKED    = (state_q == ST_LOCK);
    assign ERR       = err_q;
    assign ERR_CNT   = err_cnt_q;
    assign WRAP      = wrap_q;
    assign WRAP_CNT  = wrap_cnt_q;

endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder
//   Directed test of ring_decoder with default parameters
//   (LOCK_COUNT=4, ERR_LIMIT=2, CNT_W=8).
//   cyc(w, en, clr) drives Y_IN=w at a falling edge together with EN/CLR_CNT,
//   then advances one clock. Because the decoder registers Y_IN first, the
//   outputs seen after cyc(w_k) belong to w_(k-1), and en/clr given with w_k
//   qualify the evaluation of w_(k-1).

module tb_ring_decoder;

    logic       CLK;
    logic       RESET;
    logic       EN;
    logic       CLR_CNT;
    logic [3:0] Y_IN;
    logic [1:0] IDX;
    logic       IDX_VALID;
    logic       LOCKED;
    logic       ERR;
    logic [7:0] ERR_CNT;
    logic       WRAP;
    logic [7:0] WRAP_CNT;

    int total_cnt;
    int bad_cnt;
    int wexp;
    int r;

    ring_decoder dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .EN        (EN),
        .CLR_CNT   (CLR_CNT),
        .Y_IN      (Y_IN),
        .IDX       (IDX),
        .IDX_VALID (IDX_VALID),
        .LOCKED    (LOCKED),
        .ERR       (ERR),
        .ERR_CNT   (ERR_CNT),
        .WRAP      (WRAP),
        .WRAP_CNT  (WRAP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ring(input int k);
        logic [3:0] base;
        base = 4'b1000;
        return base >> (k % 4);
    endfunction

    task automatic cyc(input logic [3:0] w, input logic en, input logic clr);
        Y_IN    = w;
        EN      = en;
        CLR_CNT = clr;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        RESET     = 1'b1;
        EN        = 1'b1;
        CLR_CNT   = 1'b0;
        Y_IN      = 4'b0000;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // reset state
        chk("rst_idx",      IDX,       0);
        chk("rst_valid",    IDX_VALID, 0);
        chk("rst_locked",   LOCKED,    0);
        chk("rst_err",      ERR,       0);
        chk("rst_wrap",     WRAP,      0);
        chk("rst_err_cnt",  ERR_CNT,   0);
        chk("rst_wrap_cnt", WRAP_CNT,  0);

        // clean ring: lock on the 4th step (word 4), first wrap on word 8
        for (int i = 0; i < 12; i++) begin
            cyc(ring(i), 1'b1, 1'b0);
            $display("clean i=%0d idx=%0d v=%0d lk=%0d err=%0d wrap=%0d", i, IDX, IDX_VALID, LOCKED, ERR, WRAP);
            if (i == 0) begin
                chk("clean_valid0", IDX_VALID, 0);
                chk("clean_lock0",  LOCKED,    0);
            end else begin
                chk("clean_idx",   IDX,       (i - 1) % 4);
                chk("clean_valid", IDX_VALID, 1);
                chk("clean_err",   ERR,       0);
                chk("clean_lock",  LOCKED,    (i >= 5) ? 1 : 0);
                chk("clean_wrap",  WRAP,      ((i - 1) % 4 == 0 && i >= 9) ? 1 : 0);
            end
        end
        chk("clean_wrap_cnt", WRAP_CNT, 1);

        // hold tolerance: six 1000 words; the first is the wrap step
        cyc(4'b1000, 1'b1, 1'b0);
        chk("hold_pre_idx", IDX, 3);
        cyc(4'b1000, 1'b1, 1'b0);
        chk("hold_wrap",     WRAP,     1);
        chk("hold_wrap_cnt", WRAP_CNT, 2);
        for (int i = 0; i < 5; i++) begin
            cyc((i == 4) ? 4'b0100 : 4'b1000, 1'b1, 1'b0);
            $display("hold i=%0d idx=%0d lk=%0d err=%0d wrap=%0d", i, IDX, LOCKED, ERR, WRAP);
            chk("hold_wrap0",  WRAP,   0);
            chk("hold_err0",   ERR,    0);
            chk("hold_locked", LOCKED, 1);
            chk("hold_idx",    IDX,    0);
        end

        // single glitch 0110 while at idx 1
        cyc(4'b0110, 1'b1, 1'b0);
        chk("gl_pre_idx", IDX, 1);
        chk("gl_pre_wc",  WRAP_CNT, 2);
        cyc(4'b0010, 1'b1, 1'b0);
        $display("glitch idx=%0d v=%0d lk=%0d err=%0d ec=%0d", IDX, IDX_VALID, LOCKED, ERR, ERR_CNT);
        chk("gl_err",     ERR,       1);
        chk("gl_err_cnt", ERR_CNT,   1);
        chk("gl_valid",   IDX_VALID, 0);
        chk("gl_idx",     IDX,       1);
        chk("gl_locked",  LOCKED,    1);
        cyc(4'b0001, 1'b1, 1'b0);
        chk("gl_post_err",   ERR,       0);
        chk("gl_post_valid", IDX_VALID, 1);
        chk("gl_post_idx",   IDX,       2);
        chk("gl_post_lock",  LOCKED,    1);
        cyc(4'b1000, 1'b1, 1'b0);
        cyc(4'b0100, 1'b1, 1'b0);
        chk("gl_wrap_cnt", WRAP_CNT, 3);

        // loss of lock: two consecutive 0000 words
        cyc(4'b0000, 1'b1, 1'b0);
        chk("ll_idx", IDX, 1);
        cyc(4'b0000, 1'b1, 1'b0);
        chk("ll_err1",    ERR,     1);
        chk("ll_ec1",     ERR_CNT, 2);
        chk("ll_lock1",   LOCKED,  1);
        chk("ll_valid1",  IDX_VALID, 0);
        cyc(4'b1000, 1'b1, 1'b0);
        $display("loss lk=%0d err=%0d ec=%0d", LOCKED, ERR, ERR_CNT);
        chk("ll_err2",  ERR,     1);
        chk("ll_ec2",   ERR_CNT, 3);
        chk("ll_lock2", LOCKED,  0);
        // reacquire: 1 valid word plus 4 steps
        for (int i = 1; i <= 5; i++) begin
            cyc(ring(i), 1'b1, 1'b0);
            chk("re_err",  ERR,    0);
            chk("re_lock", LOCKED, (i == 5) ? 1 : 0);
        end
        chk("re_wrap",     WRAP,     0);
        chk("re_wrap_cnt", WRAP_CNT, 3);

        // reset mid-operation
        RESET = 1'b1;
        cyc(4'b0000, 1'b1, 1'b0);
        RESET = 1'b0;
        chk("mr_locked",   LOCKED,    0);
        chk("mr_err_cnt",  ERR_CNT,   0);
        chk("mr_wrap_cnt", WRAP_CNT,  0);
        chk("mr_idx",      IDX,       0);
        chk("mr_valid",    IDX_VALID, 0);

        // wrong step in ACQ: 1000,0100,0001,0010,0001,1000,0100,0010
        begin
            logic [3:0] acq_w [9];
            logic       acq_l [9];
            acq_w = '{4'b1000, 4'b0100, 4'b0001, 4'b0010, 4'b0001,
                      4'b1000, 4'b0100, 4'b0010, 4'b0001};
            acq_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 9; i++) begin
                cyc(acq_w[i], 1'b1, 1'b0);
                $display("acq i=%0d idx=%0d lk=%0d err=%0d", i, IDX, LOCKED, ERR);
                chk("acq_err",  ERR,    0);
                chk("acq_lock", LOCKED, acq_l[i]);
            end
            chk("acq_err_cnt", ERR_CNT, 0);
        end

        // saturate ERR_CNT: 260 isolated errors, each followed by a step
        for (int k = 0; k < 260; k++) begin
            cyc(4'b0000, 1'b1, 1'b0);
            chk("sat_step_err", ERR, 0);
            cyc(ring(k), 1'b1, 1'b0);
            if (k < 3 || k > 252) begin
                $display("sat k=%0d err=%0d ec=%0d lk=%0d", k, ERR, ERR_CNT, LOCKED);
            end
            chk("sat_err",    ERR,     1);
            chk("sat_cnt",    ERR_CNT, (k + 1 > 255) ? 255 : k + 1);
            chk("sat_locked", LOCKED,  1);
        end
        chk("sat_wrap_cnt", WRAP_CNT, 65);

        // CLR_CNT on an error cycle
        cyc(4'b0000, 1'b1, 1'b0);
        cyc(4'b1000, 1'b1, 1'b1);
        $display("clr err=%0d ec=%0d wc=%0d", ERR, ERR_CNT, WRAP_CNT);
        chk("clr_err",      ERR,      1);
        chk("clr_err_cnt",  ERR_CNT,  0);
        chk("clr_wrap_cnt", WRAP_CNT, 0);
        chk("clr_locked",   LOCKED,   1);
        cyc(4'b0000, 1'b1, 1'b0);
        chk("clr_wrap",   WRAP,     1);
        chk("clr_wc1",    WRAP_CNT, 1);

        // EN=0 during errors: nothing moves except IDX/IDX_VALID
        for (int i = 0; i < 3; i++) begin
            cyc((i == 2) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
            chk("en_err",    ERR,       0);
            chk("en_ec",     ERR_CNT,   0);
            chk("en_locked", LOCKED,    1);
            chk("en_valid",  IDX_VALID, 0);
            chk("en_idx",    IDX,       0);
        end
        cyc(4'b0010, 1'b1, 1'b0);
        $display("en_resume idx=%0d lk=%0d err=%0d ec=%0d wc=%0d", IDX, LOCKED, ERR, ERR_CNT, WRAP_CNT);
        chk("enr_idx",    IDX,      1);
        chk("enr_locked", LOCKED,   1);
        chk("enr_err",    ERR,      0);
        chk("enr_wc",     WRAP_CNT, 1);

        // WRAP_CNT wraps modulo 256 over 256 rotations
        wexp = 1;
        for (int j = 0; j < 1024; j++) begin
            cyc(ring(3 + j), 1'b1, 1'b0);
            r = (j + 2) % 4;
            if (r == 0) wexp = (wexp + 1) % 256;
            chk("wc_wrap", WRAP,     (r == 0) ? 1 : 0);
            chk("wc_cnt",  WRAP_CNT, wexp);
        end
        chk("wc_final",  WRAP_CNT, 1);
        chk("wc_locked", LOCKED,   1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
